sad16x16_best_mv_select: RTL and testbench

- Downstream consumer of the basic-layer search engine's 16x16 SAD bus.
- For each of the four 16x16 sub-blocks of the current 32x32 block, tracks the minimum SAD and its search position across one full search window.
- At window end, presents best SAD and signed motion vector per sub-block to the refinement/mode-decision stage.

---
 rtl/sad16x16_best_mv_select.sv | 52 +++++
 tb/tb_sad16x16_best_mv_select.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sad16x16_best_mv_select.sv
// sad16x16_best_mv_select: per-lane min-SAD/MV tracker over one search window; in: SAD16x16 lanes + search counts, out: best_sad/best_mv_x/best_mv_y, result_valid, busy, sample_count
module sad16x16_best_mv_select #(
  parameter int SAD_W = 16,
  parameter int NUM_BLK = 4,
  parameter int COL_LAST = 31,
  parameter int ROW_LAST = 127,
  parameter int COL_CENTER = 16,
  parameter int ROW_CENTER = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     sad_valid,
  input  logic [NUM_BLK*SAD_W-1:0] SAD16x16,
  input  logic [4:0]               search_column_count,
  input  logic [6:0]               search_row_count,
  output logic [NUM_BLK*SAD_W-1:0] best_sad,
  output logic [NUM_BLK*6-1:0]     best_mv_x,
  output logic [NUM_BLK*8-1:0]     best_mv_y,
  output logic                     result_valid,
  output logic                     busy,
  output logic [11:0]              sample_count
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  state_t state, state_n;
  logic take, last;
  logic [5:0] mv_x;
  logic [7:0] mv_y;
  always_comb begin
    take = state == SEARCH && sad_valid && !start;
    last = take && search_column_count == 5'(COL_LAST) && search_row_count == 7'(ROW_LAST);
    mv_x = {1'b0, search_column_count} - 6'(COL_CENTER);
    mv_y = {1'b0, search_row_count} - 8'(ROW_CENTER);
    state_n = start ? SEARCH : last ? DONE : state == SEARCH ? SEARCH : IDLE;
    result_valid = state == DONE;
    busy = state == SEARCH;
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
    sample_count <= rst || start ? '0 : take && sample_count != '1 ? sample_count + 1'b1 : sample_count;
    for (int i = 0; i < NUM_BLK; i++)
      if (rst || start) begin
        best_sad[i*SAD_W +: SAD_W] <= '1;
        best_mv_x[i*6 +: 6] <= '0;
        best_mv_y[i*8 +: 8] <= '0;
      end else if (take && SAD16x16[i*SAD_W +: SAD_W] < best_sad[i*SAD_W +: SAD_W]) begin
        best_sad[i*SAD_W +: SAD_W] <= SAD16x16[i*SAD_W +: SAD_W];
        best_mv_x[i*6 +: 6] <= mv_x;
        best_mv_y[i*8 +: 8] <= mv_y;
      end
  end
endmodule

// File: tb/tb_sad16x16_best_mv_select.sv
// tb_sad16x16_best_mv_select: randomized self-checking bench against a behavioural window model
module tb_sad16x16_best_mv_select;
  logic clk = 1'b0;
  logic rst, start, sad_valid;
  logic [63:0] sad;
  logic [4:0] col;
  logic [6:0] row;
  logic [63:0] best_sad;
  logic [23:0] best_mv_x;
  logic [31:0] best_mv_y;
  logic result_valid, busy;
  logic [11:0] sample_count;
  int errors = 0, checks = 0;
  bit armed = 0;
  int m_best[4], m_mx[4], m_my[4], m_cnt;
  bit m_search, m_rv;

  always #5 clk = ~clk;

  sad16x16_best_mv_select dut (
    .clk(clk), .rst(rst), .start(start), .sad_valid(sad_valid), .SAD16x16(sad),
    .search_column_count(col), .search_row_count(row), .best_sad(best_sad),
    .best_mv_x(best_mv_x), .best_mv_y(best_mv_y), .result_valid(result_valid),
    .busy(busy), .sample_count(sample_count)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (armed) begin
    chk("result_valid", {63'b0, result_valid}, {63'b0, m_rv});
    chk("busy", {63'b0, busy}, {63'b0, m_search});
    chk("sample_count", {52'b0, sample_count}, 64'(m_cnt));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("best_sad[%0d]", k), {48'b0, best_sad[16*k +: 16]}, 64'(m_best[k]));
      chk($sformatf("best_mv_x[%0d]", k), {58'b0, best_mv_x[6*k +: 6]}, {58'b0, 6'(m_mx[k])});
      chk($sformatf("best_mv_y[%0d]", k), {56'b0, best_mv_y[8*k +: 8]}, {56'b0, 8'(m_my[k])});
    end
  end

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      m_best[k] = 65535;
      m_mx[k] = 0;
      m_my[k] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model(input bit s, input bit v, input bit rs, input logic [63:0] sv, input int c, input int r);
    if (rs) begin
      clear_model();
      m_search = 0;
      m_rv = 0;
    end else begin
      m_rv = 0;
      if (s) begin
        clear_model();
        m_search = 1;
      end else if (m_search && v) begin
        if (m_cnt < 4095) m_cnt++;
        for (int k = 0; k < 4; k++)
          if (int'(sv[16*k +: 16]) < m_best[k]) begin
            m_best[k] = int'(sv[16*k +: 16]);
            m_mx[k] = c - 16;
            m_my[k] = r - 64;
          end
        if (c == 31 && r == 127) begin
          m_search = 0;
          m_rv = 1;
        end
      end
    end
  endtask

  task automatic step(input bit s, input bit v, input logic [63:0] sv, input int c, input int r, input bit rs = 0);
    rst = rs;
    start = s;
    sad_valid = v;
    sad = sv;
    col = c[4:0];
    row = r[6:0];
    @(posedge clk);
    model(s, v, rs, sv, c, r);
    #1;
  endtask

  task automatic gap();
    if ($urandom_range(0, 9) == 0)
      step(0, 0, {$urandom, $urandom}, $urandom_range(0, 31), $urandom_range(0, 127));
  endtask

  function automatic logic [15:0] lv(input int mode, input int k, input int c, input int r);
    case (mode)
      0: return 16'h0100;
      1: return (k == 0 && c == 16 && r == 64) || (k == 1 && c == 0 && r == 0) ||
                (k == 2 && c == 31 && r == 127) || (k == 3 && c == 20 && r == 10) ? 16'h0010 : 16'h0800;
      2: return k == 0 && ((c == 3 && r == 5) || (c == 9 && r == 70)) ? 16'h0005 : 16'h0800;
      3: return 16'hFFFF;
      default: return c == 7 && r == 40 ? 16'h0002 : 16'h0100;
    endcase
  endfunction

  task automatic raster(input int mode);
    logic [63:0] sv;
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 32; c++) begin
        gap();
        for (int k = 0; k < 4; k++) sv[16*k +: 16] = lv(mode, k, c, r);
        step(0, 1, sv, c, r);
      end
  endtask

  initial begin
    logic [63:0] sv;
    step(0, 0, 64'h0, 0, 0, 1);
    armed = 1;
    step(0, 0, 64'h0, 0, 0, 1);
    chk("rst_best_sad", best_sad, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_mv", {8'b0, best_mv_x, best_mv_y}, 64'h0);
    chk("rst_flags", {50'b0, sample_count, busy, result_valid}, 64'h0);

    step(1, 0, 64'h0, 0, 0);
    raster(0);
    chk("const_rv", {63'b0, result_valid}, 64'h1);
    chk("const_sad", best_sad, {4{16'h0100}});
    chk("const_mv_x", {40'b0, best_mv_x}, {40'b0, {4{6'h30}}});
    chk("const_mv_y", {32'b0, best_mv_y}, {32'b0, {4{8'hC0}}});
    chk("const_count_sat", {52'b0, sample_count}, 64'hFFF);
    step(0, 1, 64'h0, 5, 5);

    step(1, 0, 64'h0, 0, 0);
    raster(1);
    chk("min_sad", best_sad, {4{16'h0010}});
    chk("min_mv_x", {40'b0, best_mv_x}, {40'b0, 6'h04, 6'h0F, 6'h30, 6'h00});
    chk("min_mv_y", {32'b0, best_mv_y}, {32'b0, 8'hCA, 8'h3F, 8'hC0, 8'h00});
    step(0, 0, 64'h0, 0, 0);

    step(1, 0, 64'h0, 0, 0);
    raster(2);
    chk("tie_sad0", {48'b0, best_sad[15:0]}, 64'h5);
    chk("tie_mv_x0", {58'b0, best_mv_x[5:0]}, 64'h33);
    chk("tie_mv_y0", {56'b0, best_mv_y[7:0]}, 64'hC5);
    step(0, 0, 64'h0, 0, 0);

    step(1, 0, 64'h0, 0, 0);
    for (int i = 0; i < 1000; i++) step(0, 1, i == 500 ? {4{16'h0001}} : {4{16'h0100}}, i % 32, i / 32);
    step(1, 1, 64'h0, 31, 127);
    raster(4);
    chk("restart_sad", best_sad, {4{16'h0002}});
    step(0, 0, 64'h0, 0, 0);

    step(1, 0, 64'h0, 0, 0);
    raster(3);
    chk("ffff_rv", {63'b0, result_valid}, 64'h1);
    chk("ffff_sad", best_sad, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ffff_mv", {8'b0, best_mv_x, best_mv_y}, 64'h0);
    step(1, 0, 64'h0, 0, 0);
    chk("done_start_busy", {63'b0, busy}, 64'h1);
    for (int i = 0; i < 2000; i++) begin
      gap();
      for (int k = 0; k < 4; k++) sv[16*k +: 16] = 16'($urandom_range(0, 60));
      step(i == 1234, 1, sv, $urandom_range(0, 31), $urandom_range(0, 126));
    end
    step(0, 1, {4{16'($urandom_range(0, 60))}}, 31, 127);
    step(0, 0, 64'h0, 0, 0);

    step(1, 0, 64'h0, 0, 0);
    for (int i = 0; i < 200; i++) step(0, 1, {$urandom, $urandom}, i % 32, i / 32);
    step(0, 1, 64'h0, 31, 127, 1);
    chk("midrst_sad", best_sad, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("midrst_busy", {63'b0, busy}, 64'h0);
    for (int i = 0; i < 20; i++) step(0, 1, {$urandom, $urandom}, i, 127);
    chk("idle_sad", best_sad, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("idle_count", {52'b0, sample_count}, 64'h0);
    step(0, 0, 64'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
